// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan monitor: glyph codes, blank digit and slot indices.
package traffic_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam int unsigned ONES = 0;
    localparam int unsigned TENS = 1;

    // Blank digits contribute zero to the rebuilt count.
    function automatic logic [6:0] digit_value(input logic [3:0] d);
        return (d == DIGIT_BLANK) ? 7'd0 : {3'd0, d};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Observed display/light bus plus the decoded monitor results.
interface seg_scan_decoder_if;

    logic [1:0] seg_sel;
    logic [6:0] seg_led;
    logic [5:0] light1;
    logic [3:0] digit_ones;
    logic [3:0] digit_tens;
    logic [6:0] count_bin;
    logic       count_upd;
    logic       seg_err;
    logic [7:0] err_cnt;
    logic [5:0] light_stable;
    logic       light_chg;
    logic       scan_lost;

    modport master (
        output seg_sel, seg_led, light1,
        input  digit_ones, digit_tens, count_bin, count_upd, seg_err, err_cnt,
        input  light_stable, light_chg, scan_lost
    );

    modport slave (
        input  seg_sel, seg_led, light1,
        output digit_ones, digit_tens, count_bin, count_upd, seg_err, err_cnt,
        output light_stable, light_chg, scan_lost
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Active-high gfedcba glyph to BCD; blank maps to DIGIT_BLANK, anything unknown is illegal.
module seg7_glyph_decode
    import traffic_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic       illegal_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        illegal_o = 1'b0;
        bcd_o     = DIGIT_BLANK;
        case (glyph_i)
            GLYPH_0:     bcd_o = 4'd0;
            GLYPH_1:     bcd_o = 4'd1;
            GLYPH_2:     bcd_o = 4'd2;
            GLYPH_3:     bcd_o = 4'd3;
            GLYPH_4:     bcd_o = 4'd4;
            GLYPH_5:     bcd_o = 4'd5;
            GLYPH_6:     bcd_o = 4'd6;
            GLYPH_7:     bcd_o = 4'd7;
            GLYPH_8:     bcd_o = 4'd8;
            GLYPH_9:     bcd_o = 4'd9;
            GLYPH_BLANK: bcd_o = DIGIT_BLANK;
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 2-digit 7-seg bus and light outputs: rebuilds the count, flags bad
// glyphs and scan loss, and debounces the lights.
module seg_scan_decoder
    import traffic_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          SEL_ACT_LOW = 1'b1
) (
    input  logic               clk_50m,
    input  logic               rst,
    seg_scan_decoder_if.slave  bus
);

    localparam int unsigned StabW = $clog2(STABLE_CYC + 1);
    localparam int unsigned WdW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYC);
    localparam logic [StabW-1:0] StabCap = StabW'(STABLE_CYC - 1);
    localparam logic [WdW-1:0]   WdMax   = WdW'(TIMEOUT_CYC);

    logic [1:0]       sel_q;
    logic [6:0]       led_q;
    logic [5:0]       light_q;
    logic [StabW-1:0] stab_q, stab_d, lstab_q, lstab_d;
    logic [3:0]       digit_ones_q, digit_ones_d, digit_tens_q, digit_tens_d;
    logic             flag_ones_q, flag_ones_d, flag_tens_q, flag_tens_d;
    logic             frame_q, frame_d, first_q, first_d;
    logic [6:0]       count_bin_q, count_bin_d;
    logic             count_upd_q, count_upd_d, seg_err_q, seg_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic             scan_lost_q, scan_lost_d;
    logic [5:0]       light_stable_q, light_stable_d;
    logic             light_chg_q, light_chg_d;

    logic       seg_chg, light_in_chg, capture, lcapture;
    logic [1:0] sel_n;
    logic [6:0] led_n, frame_val;
    logic       illegal;
    logic [3:0] bcd;

    // Change is judged against the incoming pins so the counter restarts on the same edge the
    // registered copy takes the new value.
    assign seg_chg      = {bus.seg_sel, bus.seg_led} != {sel_q, led_q};
    assign light_in_chg = bus.light1 != light_q;
    assign sel_n        = SEL_ACT_LOW ? ~sel_q : sel_q;
    assign led_n        = SEG_ACT_LOW ? ~led_q : led_q;
    assign capture      = !seg_chg && (stab_q == StabCap) && (sel_n[0] ^ sel_n[1]);
    assign lcapture     = !light_in_chg && (lstab_q == StabCap);
    assign frame_val    = digit_value(digit_tens_q) * 7'd10 + digit_value(digit_ones_q);

    seg7_glyph_decode u_decode (
        .glyph_i   (led_n),
        .illegal_o (illegal),
        .bcd_o     (bcd)
    );

    always_comb begin
        stab_d         = seg_chg ? '0 : ((stab_q == StabMax) ? StabMax : stab_q + StabW'(1));
        lstab_d        = light_in_chg ? '0 : ((lstab_q == StabMax) ? StabMax : lstab_q + StabW'(1));
        digit_ones_d   = digit_ones_q;
        digit_tens_d   = digit_tens_q;
        flag_ones_d    = flag_ones_q;
        flag_tens_d    = flag_tens_q;
        frame_d        = 1'b0;
        first_d        = first_q;
        count_bin_d    = count_bin_q;
        count_upd_d    = 1'b0;
        seg_err_d      = capture && illegal;
        err_cnt_d      = err_cnt_q;
        light_stable_d = light_stable_q;
        light_chg_d    = 1'b0;

        if (capture && !illegal) begin
            if (sel_n[TENS]) begin
                digit_tens_d = bcd;
                flag_tens_d  = 1'b1;
            end else begin
                digit_ones_d = bcd;
                flag_ones_d  = 1'b1;
            end
            if (flag_ones_d && flag_tens_d) begin
                flag_ones_d = 1'b0;
                flag_tens_d = 1'b0;
                frame_d     = 1'b1;
            end
        end
        if (capture && illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;

        wd_d = capture ? '0 : ((wd_q == WdMax) ? WdMax : wd_q + WdW'(1));
        scan_lost_d = !capture && (wd_d == WdMax);
        if (scan_lost_d && !scan_lost_q) begin
            flag_ones_d = 1'b0;
            flag_tens_d = 1'b0;
        end

        if (frame_q) begin
            count_bin_d = frame_val;
            count_upd_d = first_q || (frame_val != count_bin_q);
            first_d     = 1'b0;
        end

        if (lcapture && (light_q != light_stable_q)) begin
            light_stable_d = light_q;
            light_chg_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sel_q          <= '0;
            led_q          <= '0;
            light_q        <= '0;
            stab_q         <= '0;
            lstab_q        <= '0;
            digit_ones_q   <= DIGIT_BLANK;
            digit_tens_q   <= DIGIT_BLANK;
            flag_ones_q    <= 1'b0;
            flag_tens_q    <= 1'b0;
            frame_q        <= 1'b0;
            first_q        <= 1'b1;
            count_bin_q    <= '0;
            count_upd_q    <= 1'b0;
            seg_err_q      <= 1'b0;
            err_cnt_q      <= '0;
            wd_q           <= '0;
            scan_lost_q    <= 1'b0;
            light_stable_q <= '0;
            light_chg_q    <= 1'b0;
        end else begin
            sel_q          <= bus.seg_sel;
            led_q          <= bus.seg_led;
            light_q        <= bus.light1;
            stab_q         <= stab_d;
            lstab_q        <= lstab_d;
            digit_ones_q   <= digit_ones_d;
            digit_tens_q   <= digit_tens_d;
            flag_ones_q    <= flag_ones_d;
            flag_tens_q    <= flag_tens_d;
            frame_q        <= frame_d;
            first_q        <= first_d;
            count_bin_q    <= count_bin_d;
            count_upd_q    <= count_upd_d;
            seg_err_q      <= seg_err_d;
            err_cnt_q      <= err_cnt_d;
            wd_q           <= wd_d;
            scan_lost_q    <= scan_lost_d;
            light_stable_q <= light_stable_d;
            light_chg_q    <= light_chg_d;
        end
    end

    assign bus.digit_ones   = digit_ones_q;
    assign bus.digit_tens   = digit_tens_q;
    assign bus.count_bin    = count_bin_q;
    assign bus.count_upd    = count_upd_q;
    assign bus.seg_err      = seg_err_q;
    assign bus.err_cnt      = err_cnt_q;
    assign bus.light_stable = light_stable_q;
    assign bus.light_chg    = light_chg_q;
    assign bus.scan_lost    = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE_CYC=4, TIMEOUT_CYC=200, active-low bus).
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_upd = 0;
    int   n_err = 0;
    int   n_chg = 0;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (200),
        .SEG_ACT_LOW (1'b1),
        .SEL_ACT_LOW (1'b1)
    ) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #10 clk = ~clk;

    // Pulse counters: registered pulses are seen with their pre-edge value here.
    always @(posedge clk) begin
        if (bus.count_upd === 1'b1) n_upd <= n_upd + 1;
        if (bus.seg_err === 1'b1)   n_err <= n_err + 1;
        if (bus.light_chg === 1'b1) n_chg <= n_chg + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive active-low select/segment pins, then wait n falling edges.
    task automatic hold(input logic [1:0] sel, input logic [6:0] led, input int n);
        bus.seg_sel = sel;
        bus.seg_led = led;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_light(input logic [5:0] l, input int n);
        bus.light1 = l;
        repeat (n) @(negedge clk);
    endtask

    localparam logic [1:0] SelOnes = 2'b10;
    localparam logic [1:0] SelTens = 2'b01;
    localparam logic [1:0] SelIdle = 2'b11;

    initial begin
        bus.seg_sel = SelIdle;
        bus.seg_led = 7'h7F;
        bus.light1  = 6'b000000;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ones", 32'(bus.digit_ones), 32'hF);
        check("rst_tens", 32'(bus.digit_tens), 32'hF);
        check("rst_count", 32'(bus.count_bin), 32'd0);
        check("rst_errcnt", 32'(bus.err_cnt), 32'd0);
        check("rst_lost", 32'(bus.scan_lost), 32'd0);
        check("rst_light", 32'(bus.light_stable), 32'd0);
        rst = 1'b0;

        // Idle bus: no captures, watchdog expires after 200 cycles
        repeat (190) @(negedge clk);
        check("idle_no_upd", 32'(n_upd), 32'd0);
        check("idle_lost_early", 32'(bus.scan_lost), 32'd0);
        repeat (20) @(negedge clk);
        check("idle_lost", 32'(bus.scan_lost), 32'd1);
        check("idle_ones", 32'(bus.digit_ones), 32'hF);

        // Frame "25" with exact pin-to-count_upd latency on the completing digit
        hold(SelOnes, ~7'h6D, 8);
        check("f25_lost_clr", 32'(bus.scan_lost), 32'd0);
        check("f25_ones", 32'(bus.digit_ones), 32'd5);
        hold(SelTens, ~7'h5B, 5);
        check("f25_upd_early", 32'(bus.count_upd), 32'd0);
        @(negedge clk);
        check("f25_upd", 32'(bus.count_upd), 32'd1);
        check("f25_count", 32'(bus.count_bin), 32'd25);
        repeat (2) @(negedge clk);
        check("f25_tens", 32'(bus.digit_tens), 32'd2);
        hold(SelOnes, ~7'h6D, 8);
        hold(SelTens, ~7'h5B, 8);
        check("f25_repeat_nopulse", 32'(n_upd), 32'd1);

        // Frame "19" with a 2-cycle glitch (7) inside the tens dwell
        hold(SelOnes, ~7'h6F, 8);
        hold(SelTens, ~7'h06, 2);
        hold(SelTens, ~7'h07, 2);
        hold(SelTens, ~7'h06, 8);
        check("glitch_upd", 32'(n_upd), 32'd2);
        check("glitch_count", 32'(bus.count_bin), 32'd19);
        check("glitch_tens", 32'(bus.digit_tens), 32'd1);

        // Illegal glyph on the ones slot
        hold(SelOnes, ~7'h49, 8);
        check("illegal_err", 32'(n_err), 32'd1);
        check("illegal_errcnt", 32'(bus.err_cnt), 32'd1);
        check("illegal_ones_kept", 32'(bus.digit_ones), 32'd9);
        for (int i = 0; i < 299; i++) begin
            hold(SelOnes, (i % 2 == 0) ? ~7'h7E : ~7'h49, 6);
        end
        check("illegal_err300", 32'(n_err), 32'd300);
        check("illegal_saturate", 32'(bus.err_cnt), 32'd255);
        check("illegal_no_upd", 32'(n_upd), 32'd2);
        check("illegal_lost", 32'(bus.scan_lost), 32'd0);

        // Blank tens with ones = 7
        hold(SelOnes, ~7'h07, 8);
        hold(SelTens, 7'h7F, 8);
        check("blank_tens", 32'(bus.digit_tens), 32'hF);
        check("blank_count", 32'(bus.count_bin), 32'd7);
        check("blank_upd", 32'(n_upd), 32'd3);

        // Light debounce: short excursion ignored, settled change reported once
        hold_light(6'b100001, 10);
        check("light_first", 32'(bus.light_stable), 32'b100001);
        check("light_first_chg", 32'(n_chg), 32'd1);
        hold_light(6'b010001, 3);
        hold_light(6'b100001, 6);
        check("light_short", 32'(n_chg), 32'd1);
        check("light_short_val", 32'(bus.light_stable), 32'b100001);
        hold_light(6'b010001, 8);
        check("light_settled", 32'(bus.light_stable), 32'b010001);
        check("light_settled_chg", 32'(n_chg), 32'd2);

        // Reset mid-frame discards the ones flag
        hold(SelOnes, ~7'h5B, 8);
        rst = 1'b1;
        bus.light1 = 6'b000000;
        hold(SelIdle, 7'h7F, 3);
        check("midrst_ones", 32'(bus.digit_ones), 32'hF);
        check("midrst_count", 32'(bus.count_bin), 32'd0);
        rst = 1'b0;
        hold(SelTens, ~7'h5B, 8);
        check("midrst_no_frame", 32'(n_upd), 32'd3);
        hold(SelOnes, ~7'h5B, 8);
        check("midrst_frame_upd", 32'(n_upd), 32'd4);
        check("midrst_count22", 32'(bus.count_bin), 32'd22);
        check("midrst_no_chg", 32'(n_chg), 32'd2);

        // First frame after reset pulses even when the value equals the reset count
        rst = 1'b1;
        hold(SelIdle, 7'h7F, 3);
        rst = 1'b0;
        hold(SelOnes, 7'h7F, 8);
        hold(SelTens, 7'h7F, 8);
        check("first_zero_upd", 32'(n_upd), 32'd5);
        check("first_zero_count", 32'(bus.count_bin), 32'd0);
        check("first_zero_ones", 32'(bus.digit_ones), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
